// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_master command queue: control-word layout,
// status bit, FSM encoding, command record and the read-length mask helper.
package i2c_pkg;

  localparam int CTRL_ADDR_HI = 15;
  localparam int CTRL_ADDR_LO = 9;
  localparam int CTRL_RD      = 8;
  localparam int CTRL_EN      = 7;
  localparam int CTRL_LEN_HI  = 3;
  localparam int CTRL_LEN_LO  = 0;
  localparam int MST_BUSY_BIT = 7;
  localparam int CMD_W        = 7 + 1 + 4 + 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0]   addr;
    logic         rd;
    logic [3:0]   len;
    logic [127:0] wdata;
  } cmd_t;

  function automatic logic [15:0] mk_ctrl(
    input logic [6:0] addr,
    input logic       rd,
    input logic [3:0] len
  );
    logic [15:0] c;
    c = '0;
    c[CTRL_ADDR_HI:CTRL_ADDR_LO] = addr;
    c[CTRL_RD]                   = rd;
    c[CTRL_EN]                   = 1'b1;
    c[CTRL_LEN_HI:CTRL_LEN_LO]   = len;
    return c;
  endfunction

  // (len+1)*8 peaks at 128, so an 8-bit shift amount never wraps.
  function automatic logic [127:0] len_mask(input logic [3:0] len);
    logic [7:0] sh;
    sh = ({4'd0, len} + 8'd1) << 3;
    return ~({128{1'b1}} >> sh);
  endfunction

endpackage

// File: rtl/i2c_cmdq_fifo.sv
// Synchronous FIFO holding queued I2C command records.
// Level, full and empty are all derived from registered state.
module i2c_cmdq_fifo #(
  parameter int W     = 140,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [LW-1:0] level_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign level_o = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2c_mst_cmd_queue.sv
// Command sequencer in front of i2c_master: queue, issue FSM, response regs.
// Define I2C_CMDQ_TIMEOUT_EN to build in the per-transaction watchdog.
module i2c_mst_cmd_queue
  import i2c_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 262143
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [6:0]               cmd_addr,
  input  logic                     cmd_rd,
  input  logic [3:0]               cmd_len,
  input  logic [127:0]             cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [6:0]               rsp_addr,
  output logic                     rsp_rd,
  output logic [127:0]             rsp_rdata,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic [127:0]             mst_wfifo,
  output logic [15:0]              mst_ctrl,
  input  logic [127:0]             mst_rfifo,
  input  logic [7:0]               mst_status
);

  cmd_t         push_rec;
  cmd_t         head;
  logic [CMD_W-1:0] head_raw;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         busy;
  logic         unused_status;

  state_e       state_q, state_d;
  logic [15:0]  ctrl_q, ctrl_d;
  logic [127:0] wfifo_q, wfifo_d;
  logic [6:0]   cur_addr_q, cur_addr_d;
  logic         cur_rd_q, cur_rd_d;
  logic [3:0]   cur_len_q, cur_len_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [6:0]   rsp_addr_q, rsp_addr_d;
  logic         rsp_rd_q, rsp_rd_d;
  logic [127:0] rsp_rdata_q, rsp_rdata_d;

  assign busy          = mst_status[MST_BUSY_BIT];
  assign unused_status = ^mst_status[6:0];

  // Gated by rst so the port reads 0 while reset is held.
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;

  assign push_rec.addr  = cmd_addr;
  assign push_rec.rd    = cmd_rd;
  assign push_rec.len   = cmd_len;
  assign push_rec.wdata = cmd_wdata;
  assign head           = cmd_t'(head_raw);

  i2c_cmdq_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_rec),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (full),
    .empty_o (empty),
    .level_o (q_level)
  );

`ifdef I2C_CMDQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          to_hit;
  logic          in_txn;

  assign in_txn  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
  assign to_hit  = in_txn && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign rsp_err = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYC;

  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    wfifo_d     = wfifo_q;
    cur_addr_d  = cur_addr_q;
    cur_rd_d    = cur_rd_q;
    cur_len_d   = cur_len_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
`ifdef I2C_CMDQ_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !busy) begin
          pop        = 1'b1;
          wfifo_d    = head.wdata;
          ctrl_d     = mk_ctrl(head.addr, head.rd, head.len);
          cur_addr_d = head.addr;
          cur_rd_d   = head.rd;
          cur_len_d  = head.len;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (busy) begin
          ctrl_d  = '0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = cur_addr_q;
          rsp_rd_d    = cur_rd_q;
          rsp_rdata_d = cur_rd_q ? (mst_rfifo & len_mask(cur_len_q)) : '0;
`ifdef I2C_CMDQ_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef I2C_CMDQ_TIMEOUT_EN
    // Watchdog overrides whatever the slave handshake did this cycle.
    if (to_hit) begin
      ctrl_d      = '0;
      rsp_valid_d = 1'b1;
      rsp_addr_d  = cur_addr_q;
      rsp_rd_d    = cur_rd_q;
      rsp_rdata_d = '0;
      err_d       = 1'b1;
      state_d     = ST_RESP;
    end
    if (in_txn && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
    else cnt_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      wfifo_q     <= '0;
      cur_addr_q  <= '0;
      cur_rd_q    <= 1'b0;
      cur_len_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rd_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      wfifo_q     <= wfifo_d;
      cur_addr_q  <= cur_addr_d;
      cur_rd_q    <= cur_rd_d;
      cur_len_q   <= cur_len_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef I2C_CMDQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign mst_ctrl  = ctrl_q;
  assign mst_wfifo = wfifo_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_mst_cmd_queue.sv
// Directed bench for i2c_mst_cmd_queue; the bench plays the i2c_master side.
// Timeout steps run only when I2C_CMDQ_TIMEOUT_EN is defined.
module tb_i2c_mst_cmd_queue;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [6:0]   cmd_addr;
  logic         cmd_rd;
  logic [3:0]   cmd_len;
  logic [127:0] cmd_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [6:0]   rsp_addr;
  logic         rsp_rd;
  logic [127:0] rsp_rdata;
  logic         rsp_err;
  logic [2:0]   q_level;
  logic [127:0] mst_wfifo;
  logic [15:0]  mst_ctrl;
  logic [127:0] mst_rfifo;
  logic [7:0]   mst_status;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  assign mst_status = {busy, 7'h15};

  i2c_mst_cmd_queue #(
    .DEPTH       (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_rd     (cmd_rd),
    .cmd_len    (cmd_len),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_addr   (rsp_addr),
    .rsp_rd     (rsp_rd),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .q_level    (q_level),
    .mst_wfifo  (mst_wfifo),
    .mst_ctrl   (mst_ctrl),
    .mst_rfifo  (mst_rfifo),
    .mst_status (mst_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] a, input logic r,
                     input logic [3:0] l, input logic [127:0] w);
    cmd_addr  = a;
    cmd_rd    = r;
    cmd_len   = l;
    cmd_wdata = w;
  endtask

  task automatic do_txn(input logic [6:0] a, input logic r,
                        input logic [3:0] l, input logic [127:0] w,
                        input logic [127:0] rf, input logic [15:0] ec,
                        input logic [127:0] er);
    put(a, r, l, w);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    n_chk++;
    if (q_level !== 3'd1) begin
      n_fail++;
      $error("FAIL lvl_push: got %0h", q_level);
    end
    n_chk++;
    if (mst_ctrl !== 16'h0) begin
      n_fail++;
      $error("FAIL ctrl_pre: got %0h", mst_ctrl);
    end
    tick;
    n_chk++;
    if (mst_ctrl !== ec) begin
      n_fail++;
      $error("FAIL ctrl_issue: got %0h want %0h", mst_ctrl, ec);
    end
    n_chk++;
    if (mst_wfifo !== w) begin
      n_fail++;
      $error("FAIL wfifo: got %0h want %0h", mst_wfifo, w);
    end
    busy = 1'b1;
    tick;
    n_chk++;
    if (mst_ctrl !== 16'h0) begin
      n_fail++;
      $error("FAIL ctrl_clr: got %0h", mst_ctrl);
    end
    tick;
    tick;
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL rsp_early");
    end
    mst_rfifo = rf;
    busy = 1'b0;
    tick;
    n_chk++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $error("FAIL rsp_valid");
    end
    n_chk++;
    if (rsp_addr !== a) begin
      n_fail++;
      $error("FAIL rsp_addr: got %0h want %0h", rsp_addr, a);
    end
    n_chk++;
    if (rsp_rd !== r) begin
      n_fail++;
      $error("FAIL rsp_rd: got %0h want %0h", rsp_rd, r);
    end
    n_chk++;
    if (rsp_rdata !== er) begin
      n_fail++;
      $error("FAIL rsp_rdata: got %0h want %0h", rsp_rdata, er);
    end
    n_chk++;
    if (rsp_err !== 1'b0) begin
      n_fail++;
      $error("FAIL rsp_err");
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL rsp_drop");
    end
  endtask

  initial begin
    logic [15:0] ec;
    logic        stable;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    busy      = 1'b0;
    mst_rfifo = '0;
    put(7'h0, 1'b0, 4'h0, 128'h0);
    tick;
    tick;
    n_chk++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_ready");
    end
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_rsp_valid");
    end
    n_chk++;
    if (mst_ctrl !== 16'h0) begin
      n_fail++;
      $error("FAIL rst_ctrl: got %0h", mst_ctrl);
    end
    n_chk++;
    if (q_level !== 3'd0) begin
      n_fail++;
      $error("FAIL rst_level: got %0h", q_level);
    end
    n_chk++;
    if (mst_wfifo !== 128'h0) begin
      n_fail++;
      $error("FAIL rst_wfifo: got %0h", mst_wfifo);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $error("FAIL ready_after_rst");
    end

    do_txn(7'h2d, 1'b0, 4'hf, {16{8'h5a}}, {16{8'h77}},
           16'h5a8f, 128'h0);
    do_txn(7'h2c, 1'b1, 4'h3, 128'h0,
           128'hdeadbeef_11223344_55667788_99aabbcc,
           16'h5983, {32'hdeadbeef, 96'h0});
    do_txn(7'h10, 1'b1, 4'h0, {16{8'h3c}}, {16{8'ha5}},
           16'h2180, {8'ha5, 120'h0});
    do_txn(7'h7f, 1'b1, 4'hf, 128'h1,
           128'h0123456789abcdef_fedcba9876543210,
           16'hff8f, 128'h0123456789abcdef_fedcba9876543210);
    do_txn(7'h01, 1'b0, 4'h0, 128'hffff, {16{8'hee}},
           16'h0280, 128'h0);

    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(7'h20 + 7'(i), 1'b0, 4'(i), {16{8'(i)}});
      cmd_valid = 1'b1;
      tick;
      if (i == 3) begin
        n_chk++;
        if (q_level !== 3'd4) begin
          n_fail++;
          $error("FAIL full_level: got %0h", q_level);
        end
        n_chk++;
        if (cmd_ready !== 1'b0) begin
          n_fail++;
          $error("FAIL full_ready");
        end
      end
    end
    cmd_valid = 1'b0;
    n_chk++;
    if (q_level !== 3'd4) begin
      n_fail++;
      $error("FAIL fifth_refused: got %0h", q_level);
    end
    for (int i = 0; i < 4; i++) begin
      busy = 1'b0;
      tick;
      ec = {7'h20 + 7'(i), 1'b0, 1'b1, 3'b000, 4'(i)};
      n_chk++;
      if (mst_ctrl !== ec) begin
        n_fail++;
        $error("FAIL order_ctrl: got %0h want %0h", mst_ctrl, ec);
      end
      n_chk++;
      if (q_level !== 3'(3 - i)) begin
        n_fail++;
        $error("FAIL order_level: got %0h", q_level);
      end
      busy = 1'b1;
      tick;
      n_chk++;
      if (mst_ctrl !== 16'h0) begin
        n_fail++;
        $error("FAIL order_clr: got %0h", mst_ctrl);
      end
      busy = 1'b0;
      tick;
      n_chk++;
      if (rsp_addr !== 7'h20 + 7'(i)) begin
        n_fail++;
        $error("FAIL order_rsp: got %0h", rsp_addr);
      end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
    end
    n_chk++;
    if (q_level !== 3'd0) begin
      n_fail++;
      $error("FAIL drained: got %0h", q_level);
    end

    put(7'h33, 1'b0, 4'h1, 128'h0);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    busy = 1'b1;
    tick;
    busy = 1'b0;
    tick;
    put(7'h34, 1'b1, 4'h2, 128'h0);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick;
      if (rsp_valid !== 1'b1 || rsp_addr !== 7'h33 ||
          rsp_rdata !== 128'h0 || mst_ctrl !== 16'h0)
        stable = 1'b0;
    end
    n_chk++;
    if (stable !== 1'b1) begin
      n_fail++;
      $error("FAIL hold_stable");
    end
    n_chk++;
    if (q_level !== 3'd1) begin
      n_fail++;
      $error("FAIL hold_level: got %0h", q_level);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL hold_release");
    end
    tick;
    n_chk++;
    if (mst_ctrl !== 16'h6982) begin
      n_fail++;
      $error("FAIL hold_next: got %0h", mst_ctrl);
    end
    busy = 1'b1;
    tick;
    busy = 1'b0;
    tick;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    put(7'h2d, 1'b0, 4'h0, 128'h0);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    n_chk++;
    if (mst_ctrl[7] !== 1'b1) begin
      n_fail++;
      $error("FAIL pre_rst_en");
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (mst_ctrl !== 16'h0) begin
      n_fail++;
      $error("FAIL rst_issue_ctrl: got %0h", mst_ctrl);
    end
    tick;
    rst = 1'b0;

    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    busy = 1'b1;
    tick;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    n_chk++;
    if (q_level !== 3'd1) begin
      n_fail++;
      $error("FAIL wd_level: got %0h", q_level);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (mst_ctrl !== 16'h0) begin
      n_fail++;
      $error("FAIL wd_rst_ctrl: got %0h", mst_ctrl);
    end
    n_chk++;
    if (q_level !== 3'd0) begin
      n_fail++;
      $error("FAIL wd_rst_level: got %0h", q_level);
    end
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL wd_rst_rsp");
    end
    busy = 1'b0;
    #2;
    rst = 1'b0;
    tick;
    tick;
    n_chk++;
    if (mst_ctrl !== 16'h0) begin
      n_fail++;
      $error("FAIL flushed_ctrl: got %0h", mst_ctrl);
    end
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL flushed_rsp");
    end

`ifdef I2C_CMDQ_TIMEOUT_EN
    put(7'h2c, 1'b1, 4'h3, 128'h0);
    mst_rfifo = {16{8'h99}};
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    n_chk++;
    if (mst_ctrl !== 16'h5983) begin
      n_fail++;
      $error("FAIL to_en_start: got %0h", mst_ctrl);
    end
    repeat (99) tick;
    n_chk++;
    if (mst_ctrl !== 16'h5983) begin
      n_fail++;
      $error("FAIL to_en_end: got %0h", mst_ctrl);
    end
    tick;
    n_chk++;
    if (mst_ctrl !== 16'h0) begin
      n_fail++;
      $error("FAIL to_ctrl: got %0h", mst_ctrl);
    end
    n_chk++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $error("FAIL to_valid");
    end
    n_chk++;
    if (rsp_err !== 1'b1) begin
      n_fail++;
      $error("FAIL to_err");
    end
    n_chk++;
    if (rsp_rdata !== 128'h0) begin
      n_fail++;
      $error("FAIL to_rdata: got %0h", rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
